host_mem_responder: RTL and testbench

AXI-MM sink/responder: the memory end of the host_mem channel that the copy engine drives as initiator. It accepts AR/AW/W requests and returns R/B responses from a local byte-enabled RAM. It is used as a host-memory stand-in for copy engine and PIM-less bring-up, and as local scratch memory. Reads and writes are serviced concurrently, with one burst in flight per direction.

---
 rtl/host_mem_responder_pkg.sv | 30 +++
 rtl/host_mem_responder_ram.sv | 37 +++
 rtl/host_mem_responder.sv | 260 ++++++++++++++++++++++++++
 tb/tb_host_mem_responder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/host_mem_responder_pkg.sv
// rtl/host_mem_responder_pkg.sv - shared types and line-index helper for the host memory responder
package host_mem_responder_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } t_resp;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } t_wr_state;

    typedef enum logic {
        R_IDLE,
        R_BURST
    } t_rd_state;

    // Read output buffer holds two beats: enough for 1 beat/clk with a 1-cycle RAM.
    localparam int RD_BUF_DEPTH = 2;

    // Byte address to RAM line; low offset bits are dropped, index wraps at depth.
    function automatic logic [63:0] line_index(input logic [63:0] addr,
                                               input int        offs_bits,
                                               input int        depth);
        return (addr >> offs_bits) & (64'(depth) - 64'd1);
    endfunction

endpackage

// File: rtl/host_mem_responder_ram.sv
// rtl/host_mem_responder_ram.sv - simple dual-port byte-enabled RAM with registered read-first read
module host_mem_responder_ram #(
    parameter int DATA_WIDTH = 512,
    parameter int DEPTH      = 1024,
    localparam int STRB_W    = DATA_WIDTH / 8,
    localparam int IDX_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [STRB_W-1:0]     wstrb_i,
    input  logic                  re_i,
    input  logic [IDX_W-1:0]      raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Byte-masked write and registered read; non-blocking read of mem gives old data on collision.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb_i[b]) begin
                    mem[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
        if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/host_mem_responder.sv
// rtl/host_mem_responder.sv - AXI-MM memory responder servicing one read and one write burst concurrently
module host_mem_responder
    import host_mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 512,
    parameter int ID_WIDTH   = 4,
    parameter int LEN_WIDTH  = 8,
    parameter int DEPTH      = 1024
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [LEN_WIDTH-1:0]    awlen,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic                    wvalid,
    output logic                    wready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    output logic                    bvalid,
    input  logic                    bready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    input  logic                    arvalid,
    output logic                    arready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [LEN_WIDTH-1:0]    arlen,
    input  logic [ID_WIDTH-1:0]     arid,
    output logic                    rvalid,
    input  logic                    rready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [1:0]              rresp,
    output logic                    rlast
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFFS   = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int CNT_W  = LEN_WIDTH + 1;

    logic [IDX_W-1:0] aw_idx;
    logic [IDX_W-1:0] ar_idx;

    assign aw_idx = IDX_W'(line_index(64'(awaddr), OFFS, DEPTH));
    assign ar_idx = IDX_W'(line_index(64'(araddr), OFFS, DEPTH));

    // ---------------- write side ----------------
    t_wr_state            wr_state_q, wr_state_d;
    logic [ID_WIDTH-1:0]  wid_q, wid_d;
    logic [IDX_W-1:0]     widx_q, widx_d;
    logic [CNT_W-1:0]     wcnt_q, wcnt_d;
    logic                 werr_q, werr_d;
    logic                 ram_we;
    logic                 w_final;

    assign w_final = (wcnt_q == CNT_W'(1));

    // Write burst state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_state_q <= W_IDLE;
            wid_q      <= '0;
            widx_q     <= '0;
            wcnt_q     <= '0;
            werr_q     <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            wid_q      <= wid_d;
            widx_q     <= widx_d;
            wcnt_q     <= wcnt_d;
            werr_q     <= werr_d;
        end
    end

    // Write FSM: accept AW, write each beat straight into RAM, then hold B until taken.
    always_comb begin
        wr_state_d = wr_state_q;
        wid_d      = wid_q;
        widx_d     = widx_q;
        wcnt_d     = wcnt_q;
        werr_d     = werr_q;
        awready    = 1'b0;
        wready     = 1'b0;
        bvalid     = 1'b0;
        ram_we     = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                awready = 1'b1;
                if (awvalid) begin
                    wid_d      = awid;
                    widx_d     = aw_idx;
                    wcnt_d     = CNT_W'(awlen) + CNT_W'(1);
                    werr_d     = 1'b0;
                    wr_state_d = W_DATA;
                end
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid) begin
                    ram_we = 1'b1;
                    if (wlast != w_final) begin
                        werr_d = 1'b1;
                    end
                    widx_d = widx_q + IDX_W'(1);
                    wcnt_d = wcnt_q - CNT_W'(1);
                    if (w_final) begin
                        wr_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) begin
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    assign bid   = wid_q;
    assign bresp = werr_q ? SLVERR : OKAY;

    // ---------------- read side ----------------
    t_rd_state            rd_state_q, rd_state_d;
    logic [ID_WIDTH-1:0]  rd_id_q, rd_id_d;
    logic [IDX_W-1:0]     ridx_q, ridx_d;
    logic [CNT_W-1:0]     rrem_q, rrem_d;
    logic                 pend_q;
    logic [ID_WIDTH-1:0]  pipe_id_q, pipe_id_d;
    logic                 pipe_last_q, pipe_last_d;
    logic                 issue;
    logic                 pop;
    logic [2:0]           rd_load;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // Output buffer: RD_BUF_DEPTH entries; the in-flight RAM beat bypasses it when the buffer is empty.
    logic [DATA_WIDTH-1:0] fifo_data_q [RD_BUF_DEPTH];
    logic [ID_WIDTH-1:0]   fifo_id_q   [RD_BUF_DEPTH];
    logic                  fifo_last_q [RD_BUF_DEPTH];
    logic                  wptr_q, rptr_q;
    logic [1:0]            occ_q, occ_d;
    logic                  push, fpop;

    assign rvalid  = (occ_q != 2'd0) || pend_q;
    assign pop     = rvalid && rready;
    assign rd_load = {1'b0, occ_q} + {2'b0, pend_q} - {2'b0, pop};
    assign push    = pend_q && !((occ_q == 2'd0) && pop);
    assign fpop    = pop && (occ_q != 2'd0);
    assign occ_d   = occ_q + {1'b0, push} - {1'b0, fpop};

    // Read burst state register plus the one-deep RAM-latency tag pipeline.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_state_q  <= R_IDLE;
            rd_id_q     <= '0;
            ridx_q      <= '0;
            rrem_q      <= '0;
            pend_q      <= 1'b0;
            pipe_id_q   <= '0;
            pipe_last_q <= 1'b0;
        end else begin
            rd_state_q  <= rd_state_d;
            rd_id_q     <= rd_id_d;
            ridx_q      <= ridx_d;
            rrem_q      <= rrem_d;
            pend_q      <= issue;
            pipe_id_q   <= pipe_id_d;
            pipe_last_q <= pipe_last_d;
        end
    end

    // Read FSM: accept AR, then issue one RAM read per cycle while buffer credit remains.
    always_comb begin
        rd_state_d  = rd_state_q;
        rd_id_d     = rd_id_q;
        ridx_d      = ridx_q;
        rrem_d      = rrem_q;
        pipe_id_d   = pipe_id_q;
        pipe_last_d = pipe_last_q;
        arready     = 1'b0;
        issue       = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                arready = 1'b1;
                if (arvalid) begin
                    rd_id_d    = arid;
                    ridx_d     = ar_idx;
                    rrem_d     = CNT_W'(arlen) + CNT_W'(1);
                    rd_state_d = R_BURST;
                end
            end
            R_BURST: begin
                if (rd_load < 3'(RD_BUF_DEPTH)) begin
                    issue       = 1'b1;
                    pipe_id_d   = rd_id_q;
                    pipe_last_d = (rrem_q == CNT_W'(1));
                    ridx_d      = ridx_q + IDX_W'(1);
                    rrem_d      = rrem_q - CNT_W'(1);
                    if (rrem_q == CNT_W'(1)) begin
                        rd_state_d = R_IDLE;
                    end
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // Output buffer pointers, occupancy and tags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q      <= 1'b0;
            rptr_q      <= 1'b0;
            occ_q       <= 2'd0;
            fifo_id_q   <= '{default: '0};
            fifo_last_q <= '{default: 1'b0};
        end else begin
            if (push) begin
                fifo_id_q[wptr_q]   <= pipe_id_q;
                fifo_last_q[wptr_q] <= pipe_last_q;
                wptr_q              <= ~wptr_q;
            end
            if (fpop) begin
                rptr_q <= ~rptr_q;
            end
            occ_q <= occ_d;
        end
    end

    // Output buffer data payload; no reset needed since occupancy gates its use.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wptr_q] <= ram_rdata;
        end
    end

    assign rdata = (occ_q != 2'd0) ? fifo_data_q[rptr_q] : ram_rdata;
    assign rid   = (occ_q != 2'd0) ? fifo_id_q[rptr_q]   : pipe_id_q;
    assign rlast = rvalid && ((occ_q != 2'd0) ? fifo_last_q[rptr_q] : pipe_last_q);
    assign rresp = OKAY;

    host_mem_responder_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (widx_q),
        .wdata_i (wdata),
        .wstrb_i (wstrb),
        .re_i    (issue),
        .raddr_i (ridx_q),
        .rdata_o (ram_rdata)
    );

endmodule

// File: tb/tb_host_mem_responder.sv
// tb/tb_host_mem_responder.sv - directed self-checking bench for host_mem_responder
module tb_host_mem_responder;

    localparam int AW    = 64;
    localparam int DW    = 512;
    localparam int IW    = 4;
    localparam int LW    = 8;
    localparam int DEPTH = 1024;
    localparam int SW    = DW / 8;
    localparam logic [SW-1:0] FULL = '1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          awvalid, awready;
    logic [AW-1:0] awaddr;
    logic [LW-1:0] awlen;
    logic [IW-1:0] awid;
    logic          wvalid, wready;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          wlast;
    logic          bvalid, bready;
    logic [IW-1:0] bid;
    logic [1:0]    bresp;
    logic          arvalid, arready;
    logic [AW-1:0] araddr;
    logic [LW-1:0] arlen;
    logic [IW-1:0] arid;
    logic          rvalid, rready;
    logic [DW-1:0] rdata;
    logic [IW-1:0] rid;
    logic [1:0]    rresp;
    logic          rlast;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] q_data [$];
    logic [IW-1:0] q_id   [$];
    logic          q_last [$];

    host_mem_responder #(
        .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .ID_WIDTH (IW), .LEN_WIDTH (LW), .DEPTH (DEPTH)
    ) dut (
        .clk (clk), .reset_n (reset_n),
        .awvalid (awvalid), .awready (awready), .awaddr (awaddr), .awlen (awlen), .awid (awid),
        .wvalid (wvalid), .wready (wready), .wdata (wdata), .wstrb (wstrb), .wlast (wlast),
        .bvalid (bvalid), .bready (bready), .bid (bid), .bresp (bresp),
        .arvalid (arvalid), .arready (arready), .araddr (araddr), .arlen (arlen), .arid (arid),
        .rvalid (rvalid), .rready (rready), .rdata (rdata), .rid (rid), .rresp (rresp), .rlast (rlast)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic aw_issue(input logic [AW-1:0] a, input int len, input logic [IW-1:0] id);
        int t = 0;
        awvalid = 1'b1; awaddr = a; awlen = LW'(len); awid = id;
        while (!awready && t < 100) begin @(negedge clk); t++; end
        check_eq("aw_wait", awready, 1'b1);
        @(negedge clk);
        awvalid = 1'b0;
    endtask

    task automatic w_burst(input int n, input logic [DW-1:0] base, input logic [SW-1:0] strb, input int last_at);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            wvalid = 1'b1; wdata = base + DW'(i); wstrb = strb; wlast = (i == last_at);
            while (!wready && t < 100) begin @(negedge clk); t++; end
            check_eq("w_wait", wready, 1'b1);
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic b_take(input logic [IW-1:0] eid, input logic [1:0] eresp, input string tag);
        int t = 0;
        bready = 1'b1;
        while (!bvalid && t < 100) begin @(negedge clk); t++; end
        check_eq({tag, "_bvalid"}, bvalid, 1'b1);
        check_eq({tag, "_bid"}, bid, eid);
        check_eq({tag, "_bresp"}, bresp, eresp);
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input int len, input logic [IW-1:0] id,
                      input logic [DW-1:0] base, input logic [SW-1:0] strb, input int last_at,
                      input logic [1:0] eresp, input string tag);
        aw_issue(a, len, id);
        w_burst(len + 1, base, strb, last_at);
        b_take(id, eresp, tag);
    endtask

    task automatic ar_issue(input logic [AW-1:0] a, input int len, input logic [IW-1:0] id);
        int t = 0;
        arvalid = 1'b1; araddr = a; arlen = LW'(len); arid = id;
        while (!arready && t < 100) begin @(negedge clk); t++; end
        check_eq("ar_wait", arready, 1'b1);
        @(negedge clk);
        arvalid = 1'b0;
    endtask

    // Starts at the negedge following the AR handshake edge; cycle 0 is N+1.
    task automatic collect(input int n, input bit rnd, output int first_cyc);
        int got = 0;
        int cyc = 0;
        bit stalled = 1'b0;
        logic [DW-1:0] pd;
        logic [IW-1:0] pid;
        logic pl;
        first_cyc = -1;
        q_data.delete(); q_id.delete(); q_last.delete();
        while (got < n && cyc < 600) begin
            if (stalled) begin
                check_eq("hold_rvalid", rvalid, 1'b1);
                check_eq("hold_rdata", rdata, pd);
                check_eq("hold_rid", rid, pid);
                check_eq("hold_rlast", rlast, pl);
            end
            rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rvalid) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (rready) begin
                    q_data.push_back(rdata); q_id.push_back(rid); q_last.push_back(rlast);
                    got++;
                end
            end
            stalled = rvalid && !rready;
            pd = rdata; pid = rid; pl = rlast;
            @(negedge clk);
            cyc++;
        end
        rready = 1'b0;
        check_eq("r_count", got, n);
    endtask

    task automatic rd_check(input logic [AW-1:0] a, input int len, input logic [IW-1:0] id, input bit rnd,
                            input logic [DW-1:0] exp_base, input string tag, output int fc);
        ar_issue(a, len, id);
        collect(len + 1, rnd, fc);
        for (int i = 0; i < q_data.size(); i++) begin
            check_eq($sformatf("%s_data%0d", tag, i), q_data[i], exp_base + DW'(i));
            check_eq($sformatf("%s_rid%0d", tag, i), q_id[i], id);
            check_eq($sformatf("%s_rlast%0d", tag, i), q_last[i], (i == len));
        end
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_awready"}, awready, 1'b1);
        check_eq({tag, "_arready"}, arready, 1'b1);
        check_eq({tag, "_wready"}, wready, 1'b0);
        check_eq({tag, "_bvalid"}, bvalid, 1'b0);
        check_eq({tag, "_rvalid"}, rvalid, 1'b0);
        check_eq({tag, "_rlast"}, rlast, 1'b0);
    endtask

    initial begin
        int fc;
        reset_n = 1'b0;
        awvalid = 0; awaddr = '0; awlen = '0; awid = '0;
        wvalid = 0; wdata = '0; wstrb = '0; wlast = 0; bready = 0;
        arvalid = 0; araddr = '0; arlen = '0; arid = '0; rready = 0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        check_eq("reset_bid", bid, 0);
        check_eq("reset_rid", rid, 0);
        check_eq("reset_bresp", bresp, 0);
        check_eq("reset_rresp", rresp, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Basic 4-beat write then read with latency check.
        wr(64'h0, 3, 4'd5, '0, FULL, 3, 2'b00, "t1w");
        rd_check(64'h0, 3, 4'd2, 1'b0, '0, "t1r", fc);
        check_eq("t1_first_rvalid_cyc", fc, 1);
        check_eq("t1_rresp", rresp, 2'b00);

        // Single byte-lane write over a zeroed line.
        wr(64'(10 * 64), 0, 4'd1, '0, FULL, 0, 2'b00, "t2z");
        wr(64'(10 * 64), 0, 4'd1, '1, 64'h1, 0, 2'b00, "t2b");
        rd_check(64'(10 * 64), 0, 4'd3, 1'b0, 512'hFF, "t2r", fc);

        // Burst wrapping from DEPTH-2 to line 1.
        wr(64'((DEPTH - 2) * 64), 3, 4'd7, 512'h100, FULL, 3, 2'b00, "t3w");
        rd_check(64'h0, 0, 4'd8, 1'b0, 512'h102, "t3r0", fc);
        rd_check(64'((DEPTH - 2) * 64), 3, 4'd9, 1'b0, 512'h100, "t3rw", fc);

        // Early wlast gives SLVERR but still writes every beat; next good burst is OKAY.
        wr(64'(20 * 64), 3, 4'd10, 512'h400, FULL, 1, 2'b10, "t4bad");
        rd_check(64'(20 * 64), 3, 4'd11, 1'b0, 512'h400, "t4r", fc);
        wr(64'(30 * 64), 1, 4'd12, 512'h600, FULL, 1, 2'b00, "t4good");

        // Long read under random backpressure alongside an unrelated write burst.
        wr(64'(200 * 64), 15, 4'd1, 512'h300, FULL, 15, 2'b00, "t5pre");
        fork
            begin
                int f5;
                rd_check(64'(200 * 64), 15, 4'd3, 1'b1, 512'h300, "t5r", f5);
            end
            wr(64'(100 * 64), 7, 4'd4, 512'h500, FULL, 7, 2'b00, "t5w");
        join
        rd_check(64'(100 * 64), 7, 4'd5, 1'b0, 512'h500, "t5rb", fc);

        // Reset in the middle of a read burst.
        ar_issue(64'(200 * 64), 15, 4'd6);
        rready = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_idle("midrst");
        rready = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_idle("postrst");
        rd_check(64'h0, 0, 4'd7, 1'b0, 512'h102, "t6r", fc);
        check_eq("t6_first_rvalid_cyc", fc, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
